// File: rtl/counter_game_referee.sv
// Referee for the multi-mode counter game: drives mode/init/initialValue, scores a match of
// ROUNDS_PER_MATCH rounds and hands each round result to a host over a valid/ready channel.
module counter_game_referee #(
    parameter int MULTI_MODE_COUNTER_WIDTH = 4,
    parameter int SCORE_WIDTH              = 4,
    parameter int ROUNDS_PER_MATCH         = 4,
    parameter int TIMEOUT_CYCLES           = 1024
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                cfg_valid,
    output logic                                cfg_ready,
    input  logic [1:0]                          cfg_mode,
    input  logic [MULTI_MODE_COUNTER_WIDTH-1:0] cfg_value,
    output logic [1:0]                          mode,
    output logic                                init,
    output logic [MULTI_MODE_COUNTER_WIDTH-1:0] initialValue,
    input  logic                                winner,
    input  logic                                loser,
    input  logic                                GAMEOVER,
    input  logic [1:0]                          who,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [1:0]                          res_who,
    output logic                                res_timeout,
    output logic                                res_error,
    output logic [SCORE_WIDTH-1:0]              res_winner_hits,
    output logic [SCORE_WIDTH-1:0]              res_loser_hits,
    output logic [SCORE_WIDTH-1:0]              score_winner,
    output logic [SCORE_WIDTH-1:0]              score_loser,
    output logic                                match_done
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int RW = (ROUNDS_PER_MATCH > 1) ? $clog2(ROUNDS_PER_MATCH) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] R_LAST  = RW'(ROUNDS_PER_MATCH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CFG,
        S_LOAD,
        S_RUN,
        S_REPORT
    } state_t;

    function automatic logic [SCORE_WIDTH-1:0] sat_inc(input logic [SCORE_WIDTH-1:0] v,
                                                       input logic                   en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    state_t                              state_q;
    logic                                cfg_ready_q;
    logic [1:0]                          mode_q;
    logic                                init_q;
    logic [MULTI_MODE_COUNTER_WIDTH-1:0] init_val_q;
    logic                                res_valid_q;
    logic [1:0]                          res_who_q;
    logic                                res_timeout_q;
    logic                                res_error_q;
    logic [SCORE_WIDTH-1:0]              win_hits_q, los_hits_q;
    logic [SCORE_WIDTH-1:0]              score_w_q, score_l_q;
    logic                                match_done_q;
    logic                                prev_win_q, prev_los_q;
    logic [TW-1:0]                       run_cnt_q;
    logic [RW-1:0]                       round_q;

    logic [SCORE_WIDTH-1:0] win_hits_d, los_hits_d, score_w_d, score_l_d;

    // Edge history is cleared in LOAD, so a level already high in the first RUN cycle counts.
    assign win_hits_d = sat_inc(win_hits_q, winner & ~prev_win_q);
    assign los_hits_d = sat_inc(los_hits_q, loser & ~prev_los_q);
    assign score_w_d  = sat_inc(score_w_q, 1'b1);
    assign score_l_d  = sat_inc(score_l_q, 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cfg_ready_q   <= 1'b0;
            mode_q        <= '0;
            init_q        <= 1'b0;
            init_val_q    <= '0;
            res_valid_q   <= 1'b0;
            res_who_q     <= '0;
            res_timeout_q <= 1'b0;
            res_error_q   <= 1'b0;
            win_hits_q    <= '0;
            los_hits_q    <= '0;
            score_w_q     <= '0;
            score_l_q     <= '0;
            match_done_q  <= 1'b0;
            prev_win_q    <= 1'b0;
            prev_los_q    <= 1'b0;
            run_cnt_q     <= '0;
            round_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        score_w_q    <= '0;
                        score_l_q    <= '0;
                        round_q      <= '0;
                        match_done_q <= 1'b0;
                        cfg_ready_q  <= 1'b1;
                        state_q      <= S_WAIT_CFG;
                    end
                end
                S_WAIT_CFG: begin
                    if (cfg_valid) begin
                        mode_q        <= cfg_mode;
                        init_val_q    <= cfg_value;
                        cfg_ready_q   <= 1'b0;
                        init_q        <= 1'b1;
                        res_timeout_q <= 1'b0;
                        res_error_q   <= 1'b0;
                        state_q       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    init_q     <= 1'b0;
                    win_hits_q <= '0;
                    los_hits_q <= '0;
                    prev_win_q <= 1'b0;
                    prev_los_q <= 1'b0;
                    run_cnt_q  <= '0;
                    state_q    <= S_RUN;
                end
                S_RUN: begin
                    prev_win_q <= winner;
                    prev_los_q <= loser;
                    win_hits_q <= win_hits_d;
                    los_hits_q <= los_hits_d;
                    run_cnt_q  <= run_cnt_q + 1'b1;
                    // GAMEOVER takes priority over a timeout expiring in the same cycle.
                    if (GAMEOVER) begin
                        res_who_q <= who;
                        case (who)
                            2'b10:   score_w_q   <= score_w_d;
                            2'b01:   score_l_q   <= score_l_d;
                            default: res_error_q <= 1'b1;
                        endcase
                        res_valid_q <= 1'b1;
                        state_q     <= S_REPORT;
                    end else if (run_cnt_q == TO_LAST) begin
                        res_who_q     <= 2'b00;
                        res_timeout_q <= 1'b1;
                        res_valid_q   <= 1'b1;
                        state_q       <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        round_q     <= round_q + 1'b1;
                        if (round_q == R_LAST) begin
                            match_done_q <= 1'b1;
                            state_q      <= S_IDLE;
                        end else begin
                            cfg_ready_q <= 1'b1;
                            state_q     <= S_WAIT_CFG;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cfg_ready       = cfg_ready_q;
    assign mode            = mode_q;
    assign init            = init_q;
    assign initialValue    = init_val_q;
    assign res_valid       = res_valid_q;
    assign res_who         = res_who_q;
    assign res_timeout     = res_timeout_q;
    assign res_error       = res_error_q;
    assign res_winner_hits = win_hits_q;
    assign res_loser_hits  = los_hits_q;
    assign score_winner    = score_w_q;
    assign score_loser     = score_l_q;
    assign match_done      = match_done_q;

endmodule

// File: tb/tb_counter_game_referee.sv
// Bench for counter_game_referee: directed round table plus random matches scored by a round-level model.
module tb_counter_game_referee;

    localparam int CW  = 4;
    localparam int SW  = 4;
    localparam int RPM = 4;
    localparam int TO  = 16;

    logic          clk = 1'b0;
    logic          rst, start, cfg_valid, cfg_ready;
    logic [1:0]    cfg_mode, mode, who, res_who;
    logic [CW-1:0] cfg_value, initialValue;
    logic          init, winner, loser, GAMEOVER;
    logic          res_valid, res_ready, res_timeout, res_error, match_done;
    logic [SW-1:0] res_winner_hits, res_loser_hits, score_winner, score_loser;

    always #5 clk = ~clk;

    counter_game_referee #(
        .MULTI_MODE_COUNTER_WIDTH(CW),
        .SCORE_WIDTH(SW),
        .ROUNDS_PER_MATCH(RPM),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode), .cfg_value(cfg_value),
        .mode(mode), .init(init), .initialValue(initialValue),
        .winner(winner), .loser(loser), .GAMEOVER(GAMEOVER), .who(who),
        .res_valid(res_valid), .res_ready(res_ready), .res_who(res_who),
        .res_timeout(res_timeout), .res_error(res_error),
        .res_winner_hits(res_winner_hits), .res_loser_hits(res_loser_hits),
        .score_winner(score_winner), .score_loser(score_loser), .match_done(match_done)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] value;
        int         go;     // RUN cycle carrying GAMEOVER, 0 = never
        logic [1:0] who;
        int         wt;     // winner pulses on RUN cycles 1,3,5,...
        int         lt;
        int         dly;    // cycles res_ready is held low
        logic [1:0] e_who;
        logic       e_to;
        logic       e_err;
        int         e_wh;
        int         e_lh;
        int         e_sw;
        int         e_sl;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        winner   = 1'($urandom);
        loser    = 1'($urandom);
        GAMEOVER = 1'($urandom);
        who      = 2'($urandom);
        start    = 1'($urandom);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({cfg_ready, mode, init, initialValue, res_valid, res_who, res_timeout, res_error,
                    res_winner_hits, res_loser_hits, score_winner, score_loser, match_done});
    endfunction

    task automatic start_match();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_state", 32'({cfg_ready, match_done, score_winner, score_loser}), 32'({1'b1, 1'b0, 8'h00}));
    endtask

    // Round-level reference: outcome from the first GAMEOVER within the timeout window,
    // hits as the number of runs of ones in that window.
    task automatic model(input int go, input logic [1:0] wh, input logic [31:0] wb, input logic [31:0] lb,
                         inout int sw, inout int sl, output logic [1:0] e_who, output logic e_to,
                         output logic e_err, output int e_wh, output int e_lh);
        bit ended;
        int n;
        ended = (go >= 1 && go <= TO);
        n     = ended ? go : TO;
        e_wh  = 0;
        e_lh  = 0;
        for (int k = 0; k < n; k++) begin
            if (wb[k] && (k == 0 || wb[(k > 0) ? k - 1 : 0] == 1'b0)) e_wh++;
            if (lb[k] && (k == 0 || lb[(k > 0) ? k - 1 : 0] == 1'b0)) e_lh++;
        end
        if (e_wh > 15) e_wh = 15;
        if (e_lh > 15) e_lh = 15;
        e_to  = !ended;
        e_who = ended ? wh : 2'b00;
        e_err = ended && (wh == 2'b00 || wh == 2'b11);
        if (ended && wh == 2'b10 && sw < 15) sw++;
        if (ended && wh == 2'b01 && sl < 15) sl++;
    endtask

    task automatic play_round(input logic [1:0] md, input logic [3:0] val, input int go, input logic [1:0] wh,
                              input logic [31:0] wb, input logic [31:0] lb, input int dly,
                              input logic [1:0] e_who, input logic e_to, input logic e_err,
                              input int e_wh, input int e_lh, input int e_sw, input int e_sl, input bit last);
        int n;
        bit early;
        n = (go >= 1 && go <= TO) ? go : TO;
        for (int i = 0; i < 20 && cfg_ready !== 1'b1; i++) tick();
        chk("cfg_ready_wait", 32'(cfg_ready), 32'(1));
        cfg_valid = 1'b1;
        cfg_mode  = md;
        cfg_value = val;
        junk();
        tick();
        cfg_valid = 1'b0;
        cfg_mode  = ~md;
        cfg_value = ~val;
        chk("init_pulse", 32'(init), 32'(1));
        chk("load_cfg", 32'({mode, initialValue}), 32'({md, val}));
        chk("load_flags", 32'({cfg_ready, res_valid, res_timeout, res_error}), 32'(0));
        winner   = 1'b1;
        loser    = 1'b1;
        GAMEOVER = 1'($urandom);
        who      = 2'($urandom);
        tick();
        chk("init_drop", 32'(init), 32'(0));
        chk("hits_clear", 32'({res_winner_hits, res_loser_hits}), 32'(0));
        early = 1'b0;
        for (int k = 1; k <= n; k++) begin
            winner   = wb[k-1];
            loser    = lb[k-1];
            GAMEOVER = (k == go);
            who      = (k == go) ? wh : 2'($urandom);
            tick();
            if (k < n && res_valid === 1'b1) early = 1'b1;
        end
        junk();
        chk("no_early_result", 32'(early), 32'(0));
        chk("held_cfg", 32'({mode, initialValue}), 32'({md, val}));
        chk("res_valid", 32'(res_valid), 32'(1));
        chk("res_who", 32'(res_who), 32'(e_who));
        chk("res_timeout", 32'(res_timeout), 32'(e_to));
        chk("res_error", 32'(res_error), 32'(e_err));
        chk("winner_hits", 32'(res_winner_hits), e_wh);
        chk("loser_hits", 32'(res_loser_hits), e_lh);
        chk("score_winner", 32'(score_winner), e_sw);
        chk("score_loser", 32'(score_loser), e_sl);
        for (int d = 0; d < dly; d++) begin
            res_ready = 1'b0;
            junk();
            tick();
            chk("res_hold", 32'({res_valid, res_who, res_timeout, res_error, res_winner_hits, res_loser_hits}),
                32'({1'b1, e_who, e_to, e_err, 4'(e_wh), 4'(e_lh)}));
        end
        res_ready = 1'b1;
        junk();
        start = 1'b0;
        tick();
        res_ready = 1'b0;
        start     = 1'b0;
        chk("res_drop", 32'(res_valid), 32'(0));
        chk("post_state", 32'({cfg_ready, match_done}), last ? 32'(1) : 32'(2));
    endtask

    task automatic run_table(input int first);
        vec_t       t;
        logic [31:0] wb, lb;
        for (int r = first; r < first + RPM; r++) begin
            t  = tbl[r];
            wb = '0;
            lb = '0;
            for (int i = 0; i < t.wt; i++) wb[2*i] = 1'b1;
            for (int i = 0; i < t.lt; i++) lb[2*i] = 1'b1;
            play_round(t.mode, t.value, t.go, t.who, wb, lb, t.dly, t.e_who, t.e_to, t.e_err,
                       t.e_wh, t.e_lh, t.e_sw, t.e_sl, (r == first + RPM - 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  e_who, rwho;
        logic        e_to, e_err;
        int          e_wh, e_lh, sw, sl, go;
        logic [31:0] wb, lb;

        //        mode   val    go  who   wt lt dly  e_who  e_to  e_err wh lh sw sl
        tbl[0] = '{2'b01, 4'd5,  6, 2'b10, 0, 0, 5, 2'b10, 1'b0, 1'b0, 0, 0, 1, 0};
        tbl[1] = '{2'b00, 4'd3,  0, 2'b10, 1, 0, 2, 2'b00, 1'b1, 1'b0, 1, 0, 1, 0};
        tbl[2] = '{2'b10, 4'd9, 16, 2'b01, 3, 2, 0, 2'b01, 1'b0, 1'b0, 3, 2, 1, 1};
        tbl[3] = '{2'b11, 4'd15, 3, 2'b11, 1, 1, 1, 2'b11, 1'b0, 1'b1, 1, 1, 1, 1};
        tbl[4] = '{2'b00, 4'd0,  2, 2'b10, 0, 0, 5, 2'b10, 1'b0, 1'b0, 0, 0, 1, 0};
        tbl[5] = '{2'b01, 4'd7,  4, 2'b10, 2, 0, 5, 2'b10, 1'b0, 1'b0, 2, 0, 2, 0};
        tbl[6] = '{2'b10, 4'd12, 5, 2'b01, 0, 3, 5, 2'b01, 1'b0, 1'b0, 0, 3, 2, 1};
        tbl[7] = '{2'b11, 4'd1,  1, 2'b11, 0, 0, 5, 2'b11, 1'b0, 1'b1, 0, 0, 2, 1};

        rst = 1'b1; start = 1'b1; cfg_valid = 1'b1; cfg_mode = 2'b11; cfg_value = 4'hF;
        winner = 1'b1; loser = 1'b1; GAMEOVER = 1'b1; who = 2'b10; res_ready = 1'b1;
        repeat (3) tick();
        chk("reset_outputs", all_outs(), 32'(0));
        tick();
        chk("reset_start_ignored", 32'(cfg_ready), 32'(0));
        rst = 1'b0; start = 1'b0; cfg_valid = 1'b0; GAMEOVER = 1'b0; res_ready = 1'b0;
        tick();
        chk("idle_outputs", all_outs(), 32'(0));

        start_match();
        run_table(0);
        repeat (3) tick();
        chk("idle_hold", 32'({match_done, cfg_ready, score_winner, score_loser}), 32'({1'b1, 1'b0, 4'd1, 4'd1}));

        // Reset in the middle of round 2 abandons it.
        start_match();
        play_round(2'b00, 4'd2, 3, 2'b10, 32'h0, 32'h0, 0, 2'b10, 1'b0, 1'b0, 0, 0, 1, 0, 1'b0);
        cfg_valid = 1'b1; cfg_mode = 2'b01; cfg_value = 4'd4;
        tick();
        cfg_valid = 1'b0; GAMEOVER = 1'b0; winner = 1'b0; loser = 1'b0;
        repeat (4) tick();
        chk("mid_run_no_result", 32'(res_valid), 32'(0));
        rst = 1'b1; GAMEOVER = 1'b1; who = 2'b10;
        tick();
        chk("mid_reset_outputs", all_outs(), 32'(0));
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("post_reset_idle", 32'({res_valid, cfg_ready, score_winner, score_loser, match_done}), 32'(0));
        GAMEOVER = 1'b0;

        start_match();
        run_table(4);

        for (int m = 0; m < 3; m++) begin
            start_match();
            sw = 0;
            sl = 0;
            for (int r = 0; r < RPM; r++) begin
                go   = $urandom_range(0, 20);
                rwho = 2'($urandom);
                wb   = $urandom;
                lb   = $urandom;
                model(go, rwho, wb, lb, sw, sl, e_who, e_to, e_err, e_wh, e_lh);
                play_round(2'($urandom), 4'($urandom), go, rwho, wb, lb, $urandom_range(0, 3),
                           e_who, e_to, e_err, e_wh, e_lh, sw, sl, (r == RPM - 1));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
